// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
//
// Stage 1 captures operand A, operand B and the opcode. Stage 2 holds the
// computed result and its status flags. Both stages advance independently,
// so one result per cycle is sustained and two transactions can be buffered
// while the sink stalls.
//
// Ports:
//   i_clock            single clock, rising edge
//   i_reset            synchronous, active-low reset
//   i_valid / o_ready  input handshake for {A, B, opcode}
//   i_first_operator   operand A (signed)
//   i_second_operator  operand B (signed; unsigned shift amount for shifts)
//   i_opcode           operation select
//   o_valid / i_ready  output handshake for the result
//   o_result           registered result
//   o_zero, o_negative, o_carry, o_overflow   status flags, qualified by o_valid
//   o_invalid_op       opcode of this result was not recognised
//   o_overflow_sticky  set by any delivered signed overflow
//   i_clear_sticky     clears o_overflow_sticky (a simultaneous set wins)

module alu_pipe #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_DATA-1:0]   i_first_operator,
    input  logic [NB_DATA-1:0]   i_second_operator,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_zero,
    output logic                 o_negative,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_invalid_op,
    output logic                 o_overflow_sticky,
    input  logic                 i_clear_sticky
);

    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND  = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR   = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR  = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_NOR  = NB_OPCODE'(6'b100111);
    localparam logic [NB_OPCODE-1:0] OP_SRA  = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL  = NB_OPCODE'(6'b000010);
    localparam logic [NB_OPCODE-1:0] OP_SLL  = NB_OPCODE'(6'b000000);
    localparam logic [NB_OPCODE-1:0] OP_SLT  = NB_OPCODE'(6'b101010);
    localparam logic [NB_OPCODE-1:0] OP_SLTU = NB_OPCODE'(6'b101011);

    // Shift amounts at or above the data width saturate instead of wrapping.
    localparam logic [NB_DATA:0] SHIFT_LIMIT = (NB_DATA + 1)'(NB_DATA);

    localparam int MSB = NB_DATA - 1;

    logic                 s1_valid;
    logic [NB_DATA-1:0]   s1_a;
    logic [NB_DATA-1:0]   s1_b;
    logic [NB_OPCODE-1:0] s1_op;
    logic                 s2_valid;

    logic s1_load;
    logic s2_load;

    logic [NB_DATA:0]   sum;
    logic [NB_DATA:0]   diff;
    logic [NB_DATA-1:0] sra_res;
    logic               shift_big;
    logic               slt;
    logic               sltu;

    logic [NB_DATA-1:0] nxt_result;
    logic               nxt_carry;
    logic               nxt_overflow;
    logic               nxt_invalid;

    // Stage 2 frees up when it is empty or its result is being taken; stage 1
    // frees up when it is empty or can hand its contents to stage 2. Reset is
    // folded into o_ready so nothing is offered as accepted while held.
    assign s2_load = !s2_valid || i_ready;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = i_reset && s1_load;
    assign o_valid = s2_valid;

    // The extra top bit of sum is the carry-out; of diff it is the borrow.
    assign sum       = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff      = {1'b0, s1_a} - {1'b0, s1_b};
    assign sra_res   = NB_DATA'($signed(s1_a) >>> s1_b);
    assign shift_big = ({1'b0, s1_b} >= SHIFT_LIMIT);
    assign slt       = ($signed(s1_a) < $signed(s1_b));
    assign sltu      = (s1_a < s1_b);

    // Stage 2 datapath: evaluates the captured triple into result, carry,
    // overflow and the invalid-opcode marker. Zero/negative come from the
    // result itself when it is registered.
    always_comb begin
        nxt_result   = '0;
        nxt_carry    = 1'b0;
        nxt_overflow = 1'b0;
        nxt_invalid  = 1'b0;
        case (s1_op)
            OP_ADD: begin
                nxt_result   = sum[NB_DATA-1:0];
                nxt_carry    = sum[NB_DATA];
                nxt_overflow = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                nxt_result   = diff[NB_DATA-1:0];
                nxt_carry    = diff[NB_DATA];
                nxt_overflow = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            end
            OP_AND:  nxt_result = s1_a & s1_b;
            OP_OR:   nxt_result = s1_a | s1_b;
            OP_XOR:  nxt_result = s1_a ^ s1_b;
            OP_NOR:  nxt_result = ~(s1_a | s1_b);
            OP_SRA:  nxt_result = shift_big ? {NB_DATA{s1_a[MSB]}} : sra_res;
            OP_SRL:  nxt_result = shift_big ? '0 : (s1_a >> s1_b);
            OP_SLL:  nxt_result = shift_big ? '0 : (s1_a << s1_b);
            OP_SLT:  nxt_result = {{(NB_DATA-1){1'b0}}, slt};
            OP_SLTU: nxt_result = {{(NB_DATA-1){1'b0}}, sltu};
            default: nxt_invalid = 1'b1;
        endcase
    end

    // Stage 1 register: captures the input triple whenever it is free to
    // load. Loading an idle i_valid simply empties the stage.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_load) begin
            s1_valid <= i_valid;
            s1_a     <= i_first_operator;
            s1_b     <= i_second_operator;
            s1_op    <= i_opcode;
        end
    end

    // Stage 2 register: result and flags only change when a real
    // transaction moves in, so held outputs stay stable under backpressure
    // and the all-zero reset values survive until the first result.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            s2_valid     <= 1'b0;
            o_result     <= '0;
            o_zero       <= 1'b0;
            o_negative   <= 1'b0;
            o_carry      <= 1'b0;
            o_overflow   <= 1'b0;
            o_invalid_op <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_result     <= nxt_result;
                o_zero       <= (nxt_result == '0);
                o_negative   <= nxt_result[MSB];
                o_carry      <= nxt_carry;
                o_overflow   <= nxt_overflow;
                o_invalid_op <= nxt_invalid;
            end
        end
    end

    // Sticky overflow: only a result actually taken by the sink counts, and
    // a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_overflow_sticky <= 1'b0;
        end else if (s2_valid && i_ready && o_overflow) begin
            o_overflow_sticky <= 1'b1;
        end else if (i_clear_sticky) begin
            o_overflow_sticky <= 1'b0;
        end
    end

endmodule
